// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline control unit: control-register map,
// STATUS layout, MEM-stage control ops, execution modes, exception codes, FSM states.
package pipeline_ctrl_pkg;

  // Control-register addresses (RDCR / WRCR ra/rd fields)
  localparam logic [4:0] CREG_ADDR_STATUS     = 5'd0;
  localparam logic [4:0] CREG_ADDR_PRE_STATUS = 5'd1;
  localparam logic [4:0] CREG_ADDR_EPC        = 5'd2;
  localparam logic [4:0] CREG_ADDR_EXP_VECTOR = 5'd3;
  localparam logic [4:0] CREG_ADDR_CAUSE      = 5'd4;
  localparam logic [4:0] CREG_ADDR_INT_MASK   = 5'd5;
  localparam logic [4:0] CREG_ADDR_IRQ        = 5'd6;

  // STATUS bit positions
  localparam int STATUS_EXE_MODE = 0;
  localparam int STATUS_INT_EN   = 1;

  // MEM-stage control operations
  localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

  // Execution modes
  localparam logic CPU_KERNEL_MODE = 1'b0;
  localparam logic CPU_USER_MODE   = 1'b1;

  // ISA exception codes
  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

  // Control FSM states
  typedef enum logic [0:0] {
    CTRL_ST_RUN   = 1'b0,
    CTRL_ST_FLUSH = 1'b1
  } ctrl_state_e;

  // STATUS value after reset and on exception entry: interrupts off, kernel mode
  function automatic logic [1:0] status_kernel_entry();
    return {1'b0, CPU_KERNEL_MODE};
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: stall/flush generation, control-register file and exception FSM.
// Optional macro PIPELINE_CTRL_IRQ_EN builds the external-interrupt path (IRQ / INT_MASK registers).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          IRQ_W          = 8,
  parameter logic [29:0] EXP_VECTOR_RST = 30'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       creg_rd_addr,
  output logic [31:0]      creg_rd_data,
  output logic             exe_mode,
  output logic             int_en,
  input  logic [IRQ_W-1:0] irq,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             ld_hazard,
  input  logic             mem_en,
  input  logic [29:0]      mem_pc,
  input  logic [1:0]       mem_ctrl_op,
  input  logic [4:0]       mem_dst_addr,
  input  logic [31:0]      mem_out,
  input  logic [2:0]       mem_exp_code,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic [29:0]      new_pc
);

  localparam logic [1:0] STATUS_RST = {1'b0, CPU_KERNEL_MODE};

  ctrl_state_e state_r;
  ctrl_state_e state_nx_s;
  logic        flush_r;
  logic        flush_nx_s;
  logic [29:0] new_pc_r;
  logic [29:0] new_pc_nx_s;
  logic [1:0]  status_r;
  logic [1:0]  status_nx_s;
  logic [1:0]  pre_status_r;
  logic [1:0]  pre_status_nx_s;
  logic [29:0] epc_r;
  logic [29:0] epc_nx_s;
  logic [29:0] exp_vector_r;
  logic [29:0] exp_vector_nx_s;
  logic [2:0]  cause_r;
  logic [2:0]  cause_nx_s;
  logic        stall_s;
  logic        act_s;
  logic        exp_s;
  logic        int_pend_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

`ifdef PIPELINE_CTRL_IRQ_EN
  logic [IRQ_W-1:0] irq_r;
  logic [IRQ_W-1:0] int_mask_r;
  logic [IRQ_W-1:0] int_mask_nx_s;

  assign int_pend_s = status_r[STATUS_INT_EN] & (|(irq_r & ~int_mask_r));
  assign unused_s   = ^mem_out[31:30];
`else
  assign int_pend_s = 1'b0;
  assign unused_s   = ^{irq, mem_out[31:30]};
`endif

  assign stall_s = if_busy | mem_busy;
  // A held MEM instruction only acts once the pipeline is moving again
  assign act_s   = (state_r == CTRL_ST_RUN) & mem_en & ~stall_s;
  assign exp_s   = (mem_exp_code != ISA_EXP_NO_EXP);

  assign if_stall  = stall_s | ld_hazard;
  assign id_stall  = stall_s;
  assign ex_stall  = stall_s;
  assign mem_stall = stall_s;

  assign if_flush  = flush_r;
  assign id_flush  = flush_r | (ld_hazard & ~stall_s);
  assign ex_flush  = flush_r;
  assign mem_flush = flush_r;

  assign new_pc    = new_pc_r;
  assign exe_mode  = status_r[STATUS_EXE_MODE];
  assign int_en    = status_r[STATUS_INT_EN];

  // Next-state and control-register update logic, in action priority order
  always_comb begin
    state_nx_s      = state_r;
    flush_nx_s      = 1'b0;
    new_pc_nx_s     = new_pc_r;
    status_nx_s     = status_r;
    pre_status_nx_s = pre_status_r;
    epc_nx_s        = epc_r;
    exp_vector_nx_s = exp_vector_r;
    cause_nx_s      = cause_r;
`ifdef PIPELINE_CTRL_IRQ_EN
    int_mask_nx_s   = int_mask_r;
`endif
    case (state_r)
      CTRL_ST_RUN: begin
        if (act_s && (exp_s || int_pend_s)) begin
          // EPC points at the squashed MEM instruction in both cases
          epc_nx_s        = mem_pc;
          cause_nx_s      = exp_s ? mem_exp_code : ISA_EXP_EXT_INT;
          pre_status_nx_s = status_r;
          status_nx_s     = status_kernel_entry();
          new_pc_nx_s     = exp_vector_r;
          state_nx_s      = CTRL_ST_FLUSH;
          flush_nx_s      = 1'b1;
        end else if (act_s && (mem_ctrl_op == CTRL_OP_EXRT)) begin
          status_nx_s = pre_status_r;
          new_pc_nx_s = epc_r;
          state_nx_s  = CTRL_ST_FLUSH;
          flush_nx_s  = 1'b1;
        end else if (act_s && (mem_ctrl_op == CTRL_OP_WRCR)) begin
          case (mem_dst_addr)
            CREG_ADDR_STATUS:     status_nx_s     = mem_out[1:0];
            CREG_ADDR_PRE_STATUS: pre_status_nx_s = mem_out[1:0];
            CREG_ADDR_EPC:        epc_nx_s        = mem_out[29:0];
            CREG_ADDR_EXP_VECTOR: exp_vector_nx_s = mem_out[29:0];
            CREG_ADDR_CAUSE:      cause_nx_s      = mem_out[2:0];
`ifdef PIPELINE_CTRL_IRQ_EN
            CREG_ADDR_INT_MASK:   int_mask_nx_s   = mem_out[IRQ_W-1:0];
`endif
            default:              cause_nx_s      = cause_r;
          endcase
        end else begin
          state_nx_s = CTRL_ST_RUN;
        end
      end
      // MEM contents are being discarded, so nothing is evaluated here
      CTRL_ST_FLUSH: state_nx_s = CTRL_ST_RUN;
      default:       state_nx_s = CTRL_ST_RUN;
    endcase
  end

  // State, flush flag, redirect PC and control-register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= CTRL_ST_RUN;
      flush_r      <= 1'b0;
      new_pc_r     <= 30'h0;
      status_r     <= STATUS_RST;
      pre_status_r <= STATUS_RST;
      epc_r        <= 30'h0;
      exp_vector_r <= EXP_VECTOR_RST;
      cause_r      <= ISA_EXP_NO_EXP;
    end else begin
      state_r      <= state_nx_s;
      flush_r      <= flush_nx_s;
      new_pc_r     <= new_pc_nx_s;
      status_r     <= status_nx_s;
      pre_status_r <= pre_status_nx_s;
      epc_r        <= epc_nx_s;
      exp_vector_r <= exp_vector_nx_s;
      cause_r      <= cause_nx_s;
    end
  end

`ifdef PIPELINE_CTRL_IRQ_EN
  // Interrupt sampling and mask register; mask resets to all-masked
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r      <= {IRQ_W{1'b0}};
      int_mask_r <= {IRQ_W{1'b1}};
    end else begin
      irq_r      <= irq;
      int_mask_r <= int_mask_nx_s;
    end
  end
`endif

  // Combinational RDCR read port; a same-cycle WRCR is not forwarded
  always_comb begin
    rd_data_s = 32'h0;
    case (creg_rd_addr)
      CREG_ADDR_STATUS:     rd_data_s = {30'h0, status_r};
      CREG_ADDR_PRE_STATUS: rd_data_s = {30'h0, pre_status_r};
      CREG_ADDR_EPC:        rd_data_s = {2'b00, epc_r};
      CREG_ADDR_EXP_VECTOR: rd_data_s = {2'b00, exp_vector_r};
      CREG_ADDR_CAUSE:      rd_data_s = {29'h0, cause_r};
`ifdef PIPELINE_CTRL_IRQ_EN
      CREG_ADDR_INT_MASK:   rd_data_s[IRQ_W-1:0] = int_mask_r;
      CREG_ADDR_IRQ:        rd_data_s[IRQ_W-1:0] = irq_r;
`endif
      default:              rd_data_s = 32'h0;
    endcase
  end

  assign creg_rd_data = rd_data_s;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus queues expected values, a negedge monitor compares.
// Expectations follow the PIPELINE_CTRL_IRQ_EN build setting.
module tb_pipeline_ctrl;

  localparam int          IRQ_W  = 8;
  localparam logic [29:0] EXPVEC = 30'h2A0;

  localparam int SEL_RD    = 0;
  localparam int SEL_STALL = 1;
  localparam int SEL_FLUSH = 2;
  localparam int SEL_MODE  = 3;

`ifdef PIPELINE_CTRL_IRQ_EN
  localparam logic [31:0] MASK_RST  = 32'hFF;
  localparam logic [31:0] MASK_FE   = 32'hFE;
  localparam logic [31:0] IRQ_SEEN  = 32'h1;
  localparam logic [31:0] IRQ_FLUSH = 32'hF;
  localparam logic [31:0] CAUSE_IRQ = 32'h1;
  localparam logic [31:0] PRE_IRQ   = 32'h3;
`else
  localparam logic [31:0] MASK_RST  = 32'h0;
  localparam logic [31:0] MASK_FE   = 32'h0;
  localparam logic [31:0] IRQ_SEEN  = 32'h0;
  localparam logic [31:0] IRQ_FLUSH = 32'h0;
  localparam logic [31:0] CAUSE_IRQ = 32'h2;
  localparam logic [31:0] PRE_IRQ   = 32'h0;
`endif

  logic             clk;
  logic             reset;
  logic [4:0]       creg_rd_addr;
  logic [31:0]      creg_rd_data;
  logic             exe_mode;
  logic             int_en;
  logic [IRQ_W-1:0] irq;
  logic             if_busy;
  logic             mem_busy;
  logic             ld_hazard;
  logic             mem_en;
  logic [29:0]      mem_pc;
  logic [1:0]       mem_ctrl_op;
  logic [4:0]       mem_dst_addr;
  logic [31:0]      mem_out;
  logic [2:0]       mem_exp_code;
  logic             if_stall;
  logic             id_stall;
  logic             ex_stall;
  logic             mem_stall;
  logic             if_flush;
  logic             id_flush;
  logic             ex_flush;
  logic             mem_flush;
  logic [29:0]      new_pc;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [29:0] flush_q[$];
  int          cyc;
  int          total;
  int          bad;

  pipeline_ctrl #(.IRQ_W(IRQ_W), .EXP_VECTOR_RST(EXPVEC)) dut (
    .clk(clk), .reset(reset),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .exe_mode(exe_mode), .int_en(int_en), .irq(irq),
    .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_out(mem_out), .mem_exp_code(mem_exp_code),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sel_val(input int sel);
    case (sel)
      SEL_RD:    return creg_rd_data;
      SEL_STALL: return {28'h0, if_stall, id_stall, ex_stall, mem_stall};
      SEL_FLUSH: return {28'h0, if_flush, id_flush, ex_flush, mem_flush};
      SEL_MODE:  return {30'h0, int_en, exe_mode};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_now(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string n);
    creg_rd_addr = a;
    expect_now(SEL_RD, v, n);
  endtask

  // Monitor: compares queued expectations and every flush the DUT presents
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic [29:0] pc_exp;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      act = sel_val(e.sel);
      total = total + 1;
      if (e.cyc != cyc || act !== e.exp) begin
        bad = bad + 1;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, act, e.exp);
      end
    end
    if (if_flush === 1'b1) begin
      total = total + 1;
      if (flush_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_flush cyc=%0d got=flush new_pc=%h want=no flush", cyc, new_pc);
      end else begin
        pc_exp = flush_q.pop_front();
        if (new_pc !== pc_exp) begin
          bad = bad + 1;
          $display("FAIL new_pc cyc=%0d got=%h want=%h", cyc, new_pc, pc_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; creg_rd_addr = 5'd0; irq = '0;
    if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
    mem_en = 1'b0; mem_pc = 30'h0; mem_ctrl_op = 2'd0;
    mem_dst_addr = 5'd0; mem_out = 32'h0; mem_exp_code = 3'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    expect_now(SEL_FLUSH, 32'h0, "rst_flush");
    expect_now(SEL_MODE, 32'h0, "rst_mode");
    rd(5'd0, 32'h0, "rst_status");
    tick(); rd(5'd3, 32'h2A0, "rst_expvec");
    tick(); rd(5'd5, MASK_RST, "rst_mask");
    tick(); rd(5'd6, 32'h0, "rst_irq");
    tick();

    // Undefined instruction; the held MEM exception during FLUSH must not re-fire
    mem_en = 1'b1; mem_exp_code = 3'd2; mem_pc = 30'h100;
    flush_q.push_back(EXPVEC);
    expect_now(SEL_FLUSH, 32'h0, "exc_pre_flush");
    tick();
    expect_now(SEL_FLUSH, 32'hF, "exc_flush");
    rd(5'd2, 32'h100, "exc_epc");
    tick();
    mem_en = 1'b0; mem_exp_code = 3'd0;
    expect_now(SEL_FLUSH, 32'h0, "exc_flush_end");
    rd(5'd4, 32'h2, "exc_cause");
    tick(); rd(5'd0, 32'h0, "exc_status");
    tick();

    // WRCR: read-old-value, mask, ignored writes
    mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd0; mem_out = 32'h3;
    rd(5'd0, 32'h0, "wrcr_old");
    tick();
    mem_dst_addr = 5'd5; mem_out = 32'hFE;
    rd(5'd0, 32'h3, "wrcr_status");
    expect_now(SEL_MODE, 32'h3, "wrcr_mode");
    tick();
    mem_dst_addr = 5'd6; mem_out = 32'hFFFF_FFFF;
    rd(5'd5, MASK_FE, "wrcr_mask");
    tick();
    mem_dst_addr = 5'd9; mem_out = 32'h1234;
    rd(5'd6, 32'h0, "wrcr_irq_ro");
    tick();
    mem_en = 1'b0; mem_ctrl_op = 2'd0;
    rd(5'd9, 32'h0, "wrcr_unmapped");
    tick();

    // External interrupt on unmasked line 0
    mem_en = 1'b1; mem_pc = 30'h200; irq = 8'h01;
`ifdef PIPELINE_CTRL_IRQ_EN
    flush_q.push_back(EXPVEC);
`endif
    expect_now(SEL_FLUSH, 32'h0, "irq_edge");
    tick();
    expect_now(SEL_FLUSH, 32'h0, "irq_pend");
    rd(5'd6, IRQ_SEEN, "irq_reg");
    tick();
    irq = 8'h00; mem_en = 1'b0;
    expect_now(SEL_FLUSH, IRQ_FLUSH, "irq_flush");
    tick(); rd(5'd4, CAUSE_IRQ, "irq_cause");
    tick(); rd(5'd1, PRE_IRQ, "irq_pre_status");
    tick();

    // EXRT back to EPC with PRE_STATUS restored
    mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd1; mem_out = 32'h3;
    tick();
    mem_dst_addr = 5'd2; mem_out = 32'h100;
    tick();
    mem_ctrl_op = 2'd2;
    flush_q.push_back(30'h100);
    tick();
    mem_en = 1'b0; mem_ctrl_op = 2'd0;
    expect_now(SEL_FLUSH, 32'hF, "exrt_flush");
    tick();
    expect_now(SEL_MODE, 32'h3, "exrt_mode");
    rd(5'd0, 32'h3, "exrt_status");
    tick();

    // TRAP held behind a 3-cycle data-bus wait
    mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h300; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_now(SEL_STALL, 32'hF, "trap_stall");
      expect_now(SEL_FLUSH, 32'h0, "trap_noflush");
      tick();
    end
    mem_busy = 1'b0;
    flush_q.push_back(EXPVEC);
    expect_now(SEL_STALL, 32'h0, "trap_release");
    tick();
    mem_en = 1'b0; mem_exp_code = 3'd0;
    expect_now(SEL_FLUSH, 32'hF, "trap_flush");
    tick(); rd(5'd2, 32'h300, "trap_epc");
    tick(); rd(5'd4, 32'h5, "trap_cause");
    tick(); rd(5'd1, 32'h3, "trap_pre_status");
    expect_now(SEL_MODE, 32'h0, "trap_mode");
    tick();

    // Fetch wait and load-use hazard
    if_busy = 1'b1;
    expect_now(SEL_STALL, 32'hF, "if_busy_stall");
    tick();
    if_busy = 1'b0; ld_hazard = 1'b1;
    expect_now(SEL_STALL, 32'h8, "ldh_stall");
    expect_now(SEL_FLUSH, 32'h4, "ldh_flush");
    tick();
    mem_busy = 1'b1;
    expect_now(SEL_STALL, 32'hF, "ldh_busy_stall");
    expect_now(SEL_FLUSH, 32'h0, "ldh_busy_flush");
    tick();
    mem_busy = 1'b0; ld_hazard = 1'b0;
    tick();

    // Reset during FLUSH
    mem_en = 1'b1; mem_exp_code = 3'd3; mem_pc = 30'h40;
    flush_q.push_back(EXPVEC);
    tick();
    mem_en = 1'b0; mem_exp_code = 3'd0; reset = 1'b1;
    expect_now(SEL_FLUSH, 32'hF, "rstf_flush");
    tick();
    reset = 1'b0;
    expect_now(SEL_FLUSH, 32'h0, "rstf_cleared");
    rd(5'd2, 32'h0, "rstf_epc");
    tick(); tick(); tick();

    total = total + 1;
    if (sb_q.size() != 0 || flush_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain got=%0d/%0d pending want=0/0", sb_q.size(), flush_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Pipeline control unit of the 5-stage core (IF/ID/EX/MEM/WB).
- Drives stall and flush for every pipeline register and owns the control-register file read by RDCR and written by WRCR.
- Turns MEM-stage exception codes, external interrupts and EXRT into one-cycle pipeline flushes, with the redirect PC on new_pc.
- Supplies exe_mode to the decoder stage.

Parameters:
- IRQ_W, 8, number of external interrupt lines.
- EXP_VECTOR_RST, 30'h0, reset value of the EXP_VECTOR control register (word address).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- creg_rd_addr  in  5  control-register read address (RDCR ra field)
- creg_rd_data  out  32  control-register read data, combinational
- exe_mode  out  1  STATUS[0]
- int_en  out  1  STATUS[1]
- irq  in  IRQ_W  external interrupt request levels
- if_busy  in  1  fetch bus wait
- mem_busy  in  1  data bus wait
- ld_hazard  in  1  load-use hazard from the decoder stage
- mem_en  in  1  MEM stage holds a valid instruction
- mem_pc  in  30  word PC of the MEM-stage instruction
- mem_ctrl_op  in  2  CTRL_OP_NOP / WRCR / EXRT
- mem_dst_addr  in  5  control-register address for WRCR
- mem_out  in  32  WRCR write data
- mem_exp_code  in  3  ISA_EXP_* of the MEM-stage instruction
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the corresponding pipeline register
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  clear the corresponding pipeline register to a bubble
- new_pc  out  30  redirect target, valid while if_flush=1

Behaviour:
- stall = if_busy | mem_busy.
- Stall outputs (combinational):
  - if_stall = stall | ld_hazard.
  - id_stall = ex_stall = mem_stall = stall.
- Flush outputs:
  - flush_r is a registered flag.
  - if_flush = ex_flush = mem_flush = flush_r.
  - id_flush = flush_r | (ld_hazard & ~stall).
  - A flush dominates a stall in the pipeline registers.
- Control-register map:
  - 0 STATUS {int_en, exe_mode}
  - 1 PRE_STATUS
  - 2 EPC[29:0]
  - 3 EXP_VECTOR[29:0]
  - 4 CAUSE[2:0]
  - 5 INT_MASK[IRQ_W-1:0], 1 = masked
  - 6 IRQ (read-only, registered irq)
  - all other addresses read 0; unused bits read 0.
- creg_rd_data is combinational. A read in the same cycle as a WRCR returns the old value.
- Reset values:
  - STATUS: exe_mode = CPU_KERNEL_MODE, int_en = 0; PRE_STATUS = STATUS reset value.
  - EPC = 0, EXP_VECTOR = EXP_VECTOR_RST, CAUSE = ISA_EXP_NO_EXP, INT_MASK = all 1, IRQ reg = 0.
  - State = RUN, flush_r = 0, new_pc = 0.
- irq is registered every cycle into the IRQ register. int_pend = int_en & |(irq_r & ~INT_MASK).
- FSM RUN / FLUSH. Actions are evaluated only in RUN with mem_en=1 and stall=0. Priority, highest first:
  1. mem_exp_code != NO_EXP:
     - EPC <- mem_pc, CAUSE <- mem_exp_code.
     - PRE_STATUS <- STATUS; STATUS <- {0, CPU_KERNEL_MODE}.
     - new_pc <- EXP_VECTOR, go to FLUSH.
  2. int_pend: same as 1, but CAUSE <- ISA_EXP_EXT_INT. The MEM instruction is squashed and EPC points at it.
  3. mem_ctrl_op == EXRT: STATUS <- PRE_STATUS, new_pc <- EPC, go to FLUSH.
  4. mem_ctrl_op == WRCR: write mem_out to mem_dst_addr. Writes to 6 or unmapped addresses are ignored. No flush.
- FLUSH lasts exactly 1 cycle with flush_r = 1, then returns to RUN. No action is evaluated during FLUSH, because the MEM contents are being discarded.
- Latency: the event is seen in cycle N; flush and new_pc are valid in cycle N+1; the first fetch from new_pc happens in N+1.
- With stall = 1 in RUN, all actions wait. The MEM instruction is held, so the action fires in the first non-stalled cycle.
- Reset mid-FLUSH returns to RUN with flush_r = 0 in the next cycle.

Optional Feature:
- Macro: PIPELINE_CTRL_IRQ_EN.
- Defined: interrupt path as above.
- Undefined:
  - int_pend is tied to 0.
  - The IRQ and INT_MASK registers are not built; addresses 5 and 6 read 0 and ignore writes.
  - The irq port remains but is unused.

Decomposition:
- Into cpu.h: control-register address constants CREG_ADDR_*, STATUS bit positions, CTRL_OP_*, CPU_KERNEL_MODE / CPU_USER_MODE, and the FSM state encodings CTRL_ST_RUN / CTRL_ST_FLUSH.
- ISA_EXP_* codes stay in isa.h.
- No sub-module: the register file and FSM stay in pipeline_ctrl.

Test Plan:
- Reset, then read creg 0/3/5 -> 32'h0 (kernel mode, int_en=0), EXP_VECTOR_RST, all-ones mask; all flushes 0.
- mem_en=1, mem_exp_code=UNDEF_INSN, mem_pc=30'h100 -> next cycle all flush=1, new_pc=EXP_VECTOR, EPC=30'h100, CAUSE=2, STATUS.int_en=0; cycle after that, flush=0.
- WRCR STATUS=32'h3, INT_MASK=8'hFE, then irq=8'h01 -> flush two cycles after the irq edge, CAUSE=EXT_INT, PRE_STATUS=3.
- EXRT with EPC=30'h100, PRE_STATUS=3 -> flush, new_pc=30'h100, STATUS=3.
- TRAP in MEM with mem_busy=1 for 3 cycles -> no flush, mem_stall=1; flush in the cycle after mem_busy falls.
- ld_hazard=1, stall=0 -> if_stall=1, id_flush=1, id_stall=0; ld_hazard=1 with mem_busy=1 -> id_flush=0, all stalls 1.
